// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester writeback arbiter for a single register
// file write port. Grants one requester per cycle (round-robin or fixed
// priority), registers the winning write, and counts conflict cycles.
module rf_write_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]   req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]   req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic [15:0]       conflict_cnt,
  output logic              last_grant
);

  logic              we_reg;
  logic [ADDR_W-1:0] wa_reg;
  logic [XLEN-1:0]   wd_reg;
  logic [15:0]       cnt_reg;
  logic              lg_reg;
  logic              both_valid;

  assign both_valid = req0_valid && req1_valid;

  // Grant decision: purely from valids and the last grant; nothing granted in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      if (both_valid) begin
        // last_grant==1 means requester 1 went last, so requester 0 is next
        if ((FIXED_PRIO != 0) || lg_reg) begin
          req0_ready = 1'b1;
        end else begin
          req1_ready = 1'b1;
        end
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Register the granted write; writes to register 0 are accepted but suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg <= 1'b0;
      wa_reg <= '0;
      wd_reg <= '0;
      lg_reg <= 1'b1;
    end else if (req0_ready) begin
      we_reg <= (req0_addr != '0);
      wa_reg <= req0_addr;
      wd_reg <= req0_data;
      lg_reg <= 1'b0;
    end else if (req1_ready) begin
      we_reg <= (req1_addr != '0);
      wa_reg <= req1_addr;
      wd_reg <= req1_data;
      lg_reg <= 1'b1;
    end else begin
      we_reg <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters contend.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (both_valid && (cnt_reg != 16'hFFFF)) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign rf_we        = we_reg;
  assign rf_wa        = wa_reg;
  assign rf_wd        = wd_reg;
  assign conflict_cnt = cnt_reg;
  assign last_grant   = lg_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: runs a round-robin and a fixed-priority
// instance side by side on shared inputs, checking a directed vector table,
// hand sequences and randomized traffic against a transaction-level model.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        we   [2];
  logic [4:0]  wa   [2];
  logic [31:0] wd   [2];
  logic [15:0] cnt  [2];
  logic        lg   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.ADDR_W(5), .XLEN(32), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0[0]),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1[0]),
    .rf_we(we[0]), .rf_wa(wa[0]), .rf_wd(wd[0]),
    .conflict_cnt(cnt[0]), .last_grant(lg[0])
  );

  rf_write_arbiter #(.ADDR_W(5), .XLEN(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0[1]),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1[1]),
    .rf_we(we[1]), .rf_wa(wa[1]), .rf_wd(wd[1]),
    .conflict_cnt(cnt[1]), .last_grant(lg[1])
  );

  // Transaction-level model state per instance (0 = round-robin, 1 = fixed)
  int          m_lg  [2];
  int          m_cnt [2];
  bit          m_we  [2];
  int          m_wa  [2];
  logic [31:0] m_wd  [2];
  logic        s_r0  [2];
  logic        s_r1  [2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // One clock cycle: drive, check grants against the model, clock, check registered outputs.
  task automatic cycle(input logic rst, input logic iv0, input logic iv1,
                       input logic [4:0] ia0, input logic [4:0] ia1,
                       input logic [31:0] id0, input logic [31:0] id1);
    int g;
    reset = rst; v0 = iv0; v1 = iv1; a0 = ia0; a1 = ia1; d0 = id0; d1 = id1;
    #1;
    for (int k = 0; k < 2; k++) begin
      // winner: -1 none, else requester index
      if (rst || (!iv0 && !iv1)) g = -1;
      else if (iv0 && !iv1) g = 0;
      else if (iv1 && !iv0) g = 1;
      else if (k == 1) g = 0;
      else g = 1 - m_lg[k];
      s_r0[k] = rdy0[k];
      s_r1[k] = rdy1[k];
      chk("req0_ready", k, {31'd0, rdy0[k]}, (g == 0) ? 32'd1 : 32'd0);
      chk("req1_ready", k, {31'd0, rdy1[k]}, (g == 1) ? 32'd1 : 32'd0);
      if (rst) begin
        m_we[k] = 0; m_wa[k] = 0; m_wd[k] = 0; m_cnt[k] = 0; m_lg[k] = 1;
      end else begin
        if (g >= 0) begin
          m_lg[k] = g;
          m_wa[k] = (g == 0) ? int'(ia0) : int'(ia1);
          m_wd[k] = (g == 0) ? id0 : id1;
          m_we[k] = (m_wa[k] != 0);
        end else begin
          m_we[k] = 0;
        end
        if (iv0 && iv1 && m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rf_we", k, {31'd0, we[k]}, {31'd0, m_we[k]});
      if (m_we[k] || rst) begin
        chk("rf_wa", k, {27'd0, wa[k]}, m_wa[k]);
        chk("rf_wd", k, wd[k], m_wd[k]);
      end
      chk("conflict_cnt", k, {16'd0, cnt[k]}, m_cnt[k]);
      chk("last_grant", k, {31'd0, lg[k]}, m_lg[k]);
    end
  endtask

  typedef struct {
    logic        rst, v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        r0, r1, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cnt;
    logic        lg;
  } vec_t;

  vec_t tbl [17];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_lg[k] = 1; m_cnt[k] = 0; m_we[k] = 0; m_wa[k] = 0; m_wd[k] = 0;
    end
    reset = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;

    // Expected values for the round-robin instance
    //           rst v0 v1 a0 a1  d0            d1        r0 r1 we wa  wd            cnt lg
    tbl[0]  = '{1, 0, 0, 0, 0, 0,            0,        0, 0, 0, 0, 0,            0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,            0,        0, 0, 0, 0, 0,            0, 1};
    tbl[2]  = '{0, 1, 0, 5, 0, 32'hDEADBEEF, 0,        1, 0, 1, 5, 32'hDEADBEEF, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,            0,        0, 0, 0, 0, 0,            0, 0};
    tbl[4]  = '{0, 0, 1, 0, 2, 0,            32'h22,   0, 1, 1, 2, 32'h22,       0, 1};
    tbl[5]  = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   1, 0, 1, 1, 32'h11,       1, 0};
    tbl[6]  = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   0, 1, 1, 2, 32'h22,       2, 1};
    tbl[7]  = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   1, 0, 1, 1, 32'h11,       3, 0};
    tbl[8]  = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   0, 1, 1, 2, 32'h22,       4, 1};
    tbl[9]  = '{0, 0, 1, 0, 0, 0,            32'h1234, 0, 1, 0, 0, 0,            4, 1};
    tbl[10] = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   1, 0, 1, 1, 32'h11,       5, 0};
    tbl[11] = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   0, 1, 1, 2, 32'h22,       6, 1};
    tbl[12] = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   1, 0, 1, 1, 32'h11,       7, 0};
    tbl[13] = '{1, 1, 1, 1, 2, 32'h11,       32'h22,   0, 0, 0, 0, 0,            0, 1};
    tbl[14] = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   1, 0, 1, 1, 32'h11,       1, 0};
    tbl[15] = '{0, 1, 1, 1, 2, 32'h11,       32'h22,   0, 1, 1, 2, 32'h22,       2, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0,            0,        0, 0, 0, 0, 0,            2, 1};

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk("tbl_r0", 0, {31'd0, s_r0[0]}, {31'd0, tbl[i].r0});
      chk("tbl_r1", 0, {31'd0, s_r1[0]}, {31'd0, tbl[i].r1});
      chk("tbl_we", 0, {31'd0, we[0]}, {31'd0, tbl[i].we});
      if (tbl[i].we || tbl[i].rst) begin
        chk("tbl_wa", 0, {27'd0, wa[0]}, {27'd0, tbl[i].wa});
        chk("tbl_wd", 0, wd[0], tbl[i].wd);
      end
      chk("tbl_cnt", 0, {16'd0, cnt[0]}, {16'd0, tbl[i].cnt});
      chk("tbl_lg", 0, {31'd0, lg[0]}, {31'd0, tbl[i].lg});
      $display("[TB] row %0d rst=%0d v=%0d%0d ready=%0d%0d we=%0d wa=%0d cnt=%0d lg=%0d",
               i, tbl[i].rst, tbl[i].v0, tbl[i].v1, s_r0[0], s_r1[0], we[0], wa[0], cnt[0], lg[0]);
    end

    // Fixed priority: requester 0 always wins a conflict
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 3, 4, 32'hA0 + i, 32'hB0 + i);
      chk("fp_r0", 1, {31'd0, s_r0[1]}, 32'd1);
      chk("fp_r1", 1, {31'd0, s_r1[1]}, 32'd0);
      chk("fp_wa", 1, {27'd0, wa[1]}, 32'd3);
      $display("[TB] fixed cycle %0d ready=%0d%0d wa=%0d cnt=%0d", i, s_r0[1], s_r1[1], wa[1], cnt[1]);
    end
    chk("fp_cnt", 1, {16'd0, cnt[1]}, 32'd3);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("fp_idle_we", 1, {31'd0, we[1]}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] ra0, ra1;
      ra0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ra1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), ra0, ra1, $urandom, $urandom);
    end

    // Conflict counter saturation
    cycle(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = 5'd7; a1 = 5'd9;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("cnt_sat", 0, {16'd0, cnt[0]}, 32'hFFFF);
    chk("cnt_sat", 1, {16'd0, cnt[1]}, 32'hFFFF);
    $display("[TB] saturation cnt_rr=%0h cnt_fp=%0h", cnt[0], cnt[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, register address width; SHALL match the register file address width.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter FIXED_PRIO, default 0; 0 selects round-robin arbitration, 1 selects fixed priority to requester 0.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0_valid  in  1  requester 0 (ALU writeback) has a write pending.
REQ-007 req0_addr  in  ADDR_W  requester 0 destination register.
REQ-008 req0_data  in  XLEN  requester 0 write data.
REQ-009 req0_ready  out  1  requester 0 write accepted this cycle.
REQ-010 req1_valid, req1_addr, req1_data, req1_ready  SHALL mirror REQ-006..009 for requester 1 (load writeback).
REQ-011 rf_we  out  1  registered write enable to the register file write port.
REQ-012 rf_wa  out  ADDR_W  registered write address.
REQ-013 rf_wd  out  XLEN  registered write data.
REQ-014 conflict_cnt  out  16  count of cycles in which both requesters were valid.
REQ-015 last_grant  out  1  index of the most recently granted requester.

Function
REQ-016 A transfer SHALL occur on reqN when reqN_valid and reqN_ready are both 1 at a rising edge.
REQ-017 At most one of req0_ready/req1_ready SHALL be 1 in any cycle.
REQ-018 reqN_ready SHALL be combinational from the valids and last_grant; it SHALL not depend on rf_we or reqN_data.
REQ-019 Only req0 valid: req0_ready=1. Only req1 valid: req1_ready=1. Neither valid: both ready=0.
REQ-020 Both valid, FIXED_PRIO=1: req0_ready=1.
REQ-021 Both valid, FIXED_PRIO=0: the requester not equal to last_grant SHALL be granted.
REQ-022 last_grant SHALL load the granted index on every transfer and hold otherwise.
REQ-023 A requester SHALL hold valid, addr and data stable until it sees ready; the arbiter SHALL not buffer ungranted requests.
REQ-024 Latency: on a transfer at edge T, rf_we=1 with rf_wa/rf_wd equal to the transferred addr/data SHALL be visible after edge T and until edge T+1.
REQ-025 A transfer with addr=0 SHALL be accepted (ready=1) but SHALL drive rf_we=0 the following cycle; rf_wa/rf_wd are don't-care then.
REQ-026 A cycle with no transfer SHALL produce rf_we=0 the following cycle.
REQ-027 Back-to-back transfers SHALL give one rf_we pulse per cycle with no bubble; throughput SHALL be one write per cycle.
REQ-028 conflict_cnt SHALL increment by 1 each cycle with req0_valid=req1_valid=1 and SHALL saturate at 16'hFFFF.
REQ-029 Round-robin fairness: with both valid continuously, grants SHALL strictly alternate, so no requester waits more than 1 cycle.

Reset
REQ-030 While reset=1 at an edge: rf_we=0, rf_wa=0, rf_wd=0, conflict_cnt=0, last_grant=1 (so req1 is given precedence 0... no: requester 0 wins the first conflict).
REQ-031 While reset=1, req0_ready and req1_ready SHALL be 0 regardless of valids; no transfer SHALL occur.
REQ-032 Reset asserted mid-stream SHALL drop the write registered at that edge (rf_we=0 next cycle); pending requesters SHALL keep valid and be served after reset deasserts.

Verification
REQ-033 Reset then idle -> rf_we=0, conflict_cnt=0, last_grant=1, both ready=0.
REQ-034 req0 only, addr=5 data=0xDEADBEEF for 1 cycle -> req0_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-035 Round-robin, both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants 0,1,0,1; rf_wa sequence 1,2,1,2; conflict_cnt=4.
REQ-036 FIXED_PRIO=1, both valid 3 cycles -> req0_ready=1 all cycles, req1_ready=0; conflict_cnt=3.
REQ-037 req1 addr=0 data=0x1234 -> req1_ready=1; next cycle rf_we=0.
REQ-038 reset asserted for one cycle during continuous both-valid stream -> both ready=0 that cycle, rf_we=0 next cycle, conflict_cnt=0, req0 granted first afterwards.
